// File: rtl/qmf_analysis_core.sv
// Two-band QMF analysis core: decimate-by-2 FIR pair sharing one prototype.
// Ports: s_* sample in, h0_coef_flat taps, m_* low/high subband pair out.
module qmf_analysis_core #(
    parameter int DATAW     = 16,
    parameter int COEFW     = 16,
    parameter int NTAPS     = 128,
    parameter int OUT_SHIFT = 15
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [DATAW-1:0] s_data,
    input  logic [NTAPS*COEFW-1:0]  h0_coef_flat,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [DATAW-1:0] m_low,
    output logic signed [DATAW-1:0] m_high
);

    localparam int KW = $clog2(NTAPS);
    localparam int PW = DATAW + COEFW + 1;
    localparam int AW = PW + KW;

    localparam logic signed [AW-1:0] SMAX =
        {{(AW-DATAW+1){1'b0}}, {(DATAW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN =
        {{(AW-DATAW+1){1'b1}}, {(DATAW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic                    phase;
    logic signed [DATAW-1:0] x [NTAPS];
    logic signed [COEFW-1:0] h0 [NTAPS];
    logic [KW-1:0]           k;
    logic signed [AW-1:0]    acc_lo;
    logic signed [AW-1:0]    acc_hi;

    logic                    accept;
    logic                    last_tap;
    logic signed [DATAW-1:0] x_k;
    logic signed [COEFW-1:0] h_k;
    logic signed [COEFW:0]   h1_k;
    logic signed [PW-1:0]    x_e;
    logic signed [PW-1:0]    h0_e;
    logic signed [PW-1:0]    h1_e;
    logic signed [PW-1:0]    prod_lo;
    logic signed [PW-1:0]    prod_hi;
    logic signed [AW-1:0]    lo_sh;
    logic signed [AW-1:0]    hi_sh;

    for (genvar g = 0; g < NTAPS; g++) begin : g_coef
        assign h0[g] = h0_coef_flat[g*COEFW +: COEFW];
    end

    assign s_ready  = (state == IDLE);
    assign accept   = s_valid && s_ready;
    assign last_tap = (k == KW'(NTAPS - 1));

    assign x_k = x[k];
    assign h_k = h0[k];

    // One extra bit so negating the most negative coefficient cannot wrap.
    assign h1_k = k[0] ? -{h_k[COEFW-1], h_k} : {h_k[COEFW-1], h_k};

    assign x_e  = {{(COEFW+1){x_k[DATAW-1]}}, x_k};
    assign h0_e = {{(DATAW+1){h_k[COEFW-1]}}, h_k};
    assign h1_e = {{DATAW{h1_k[COEFW]}}, h1_k};

    assign prod_lo = x_e * h0_e;
    assign prod_hi = x_e * h1_e;

    assign lo_sh = acc_lo >>> OUT_SHIFT;
    assign hi_sh = acc_hi >>> OUT_SHIFT;

    function automatic logic signed [DATAW-1:0] sat(
        input logic signed [AW-1:0] v
    );
        if (v > SMAX) begin
            sat = SMAX[DATAW-1:0];
        end else if (v < SMIN) begin
            sat = SMIN[DATAW-1:0];
        end else begin
            sat = v[DATAW-1:0];
        end
    endfunction

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept && phase) state_nx = MAC;
            MAC:  if (last_tap) state_nx = OUT;
            OUT:  if (m_valid && m_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            phase   <= 1'b0;
            k       <= '0;
            acc_lo  <= '0;
            acc_hi  <= '0;
            m_valid <= 1'b0;
            m_low   <= '0;
            m_high  <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                x[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (accept) begin
                phase <= ~phase;
                x[0]  <= s_data;
                for (int i = 1; i < NTAPS; i++) begin
                    x[i] <= x[i-1];
                end
            end
            unique case (state)
                IDLE: begin
                    if (accept && phase) begin
                        acc_lo <= '0;
                        acc_hi <= '0;
                        k      <= '0;
                    end
                end
                MAC: begin
                    acc_lo <= acc_lo + {{KW{prod_lo[PW-1]}}, prod_lo};
                    acc_hi <= acc_hi + {{KW{prod_hi[PW-1]}}, prod_hi};
                    k      <= k + KW'(1);
                end
                OUT: begin
                    // First OUT cycle loads the pair; later cycles wait.
                    if (!m_valid) begin
                        m_low   <= sat(lo_sh);
                        m_high  <= sat(hi_sh);
                        m_valid <= 1'b1;
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qmf_analysis_core.sv
// Self-checking bench for qmf_analysis_core against a sum-of-products model.
// Drives random and directed samples; checks latency, saturation, resets.
module tb_qmf_analysis_core;

    localparam int DATAW     = 16;
    localparam int COEFW     = 16;
    localparam int NTAPS     = 128;
    localparam int OUT_SHIFT = 15;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [DATAW-1:0] s_data;
    logic [NTAPS*COEFW-1:0]  h0_coef_flat;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [DATAW-1:0] m_low;
    logic signed [DATAW-1:0] m_high;

    int errors = 0;
    int checks = 0;

    longint xm [NTAPS];
    int     hm [NTAPS];

    always #5 clk = ~clk;

    qmf_analysis_core #(
        .DATAW(DATAW),
        .COEFW(COEFW),
        .NTAPS(NTAPS),
        .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .h0_coef_flat(h0_coef_flat),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_low(m_low),
        .m_high(m_high)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_coefs;
        for (int i = 0; i < NTAPS; i++) begin
            h0_coef_flat[i*COEFW +: COEFW] = hm[i][COEFW-1:0];
        end
    endtask

    task automatic zero_coefs;
        for (int i = 0; i < NTAPS; i++) hm[i] = 0;
    endtask

    task automatic model_clear;
        for (int i = 0; i < NTAPS; i++) xm[i] = 0;
    endtask

    task automatic model_push(input longint d);
        for (int i = NTAPS - 1; i > 0; i--) xm[i] = xm[i-1];
        xm[0] = d;
    endtask

    function automatic longint clamp(input longint v);
        longint hi = (longint'(1) << (DATAW - 1)) - 1;
        longint lo = -(longint'(1) << (DATAW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Low band: plain dot product; high band: odd taps negated.
    task automatic model_out(output logic signed [DATAW-1:0] el,
                             output logic signed [DATAW-1:0] eh);
        longint lo = 0;
        longint hi = 0;
        longint t;
        for (int i = 0; i < NTAPS; i++) begin
            t  = xm[i] * longint'(hm[i]);
            lo = lo + t;
            hi = (i % 2 == 0) ? hi + t : hi - t;
        end
        lo = clamp(lo >>> OUT_SHIFT);
        hi = clamp(hi >>> OUT_SHIFT);
        el = lo[DATAW-1:0];
        eh = hi[DATAW-1:0];
    endtask

    task automatic send(input logic signed [DATAW-1:0] d);
        int n = 0;
        while (!s_ready && n < 400) begin
            step();
            n++;
        end
        if (!s_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: s_ready=%0b want 1", s_ready);
        end
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid = 1'b0;
        model_push(longint'(d));
    endtask

    task automatic wait_out(input int delay,
                            output logic signed [DATAW-1:0] lo,
                            output logic signed [DATAW-1:0] hi);
        int n = 0;
        while (!m_valid && n < 400) begin
            step();
            n++;
        end
        if (!m_valid) begin
            errors++;
            checks++;
            $display("FAIL out_timeout: m_valid=%0b want 1", m_valid);
        end
        repeat (delay) step();
        lo      = m_low;
        hi      = m_high;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic test_reset;
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        zero_coefs();
        set_coefs();
        model_clear();
        repeat (3) step();
        rstn = 1'b1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_m_valid: got %0b want 0", m_valid);
        end
        checks++;
        if (m_low !== '0 || m_high !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %0d/%0d want 0/0", m_low, m_high);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_ready: got %0b want 1", s_ready);
        end
    endtask

    task automatic test_tap0;
        logic signed [DATAW-1:0] lo, hi;
        zero_coefs();
        hm[0] = 16384;
        set_coefs();
        send(16'sd1000);
        send(16'sd2000);
        wait_out(0, lo, hi);
        checks++;
        if (lo !== 16'sd1000 || hi !== 16'sd1000) begin
            errors++;
            $display("FAIL tap0: got %0d/%0d want 1000/1000", lo, hi);
        end
    endtask

    task automatic test_tap1;
        logic signed [DATAW-1:0] lo, hi;
        zero_coefs();
        hm[1] = 16384;
        set_coefs();
        send(16'sd1000);
        send(16'sd2000);
        wait_out(2, lo, hi);
        checks++;
        if (lo !== 16'sd500 || hi !== -16'sd500) begin
            errors++;
            $display("FAIL tap1: got %0d/%0d want 500/-500", lo, hi);
        end
        send(16'sd0);
        send(16'sd0);
        wait_out(0, lo, hi);
        checks++;
        if (lo !== 16'sd0 || hi !== 16'sd0) begin
            errors++;
            $display("FAIL tap1_zero: got %0d/%0d want 0/0", lo, hi);
        end
    endtask

    task automatic test_latency;
        logic signed [DATAW-1:0] el, eh, lo, hi;
        int lowcnt = 0;
        int first_v = 0;
        zero_coefs();
        hm[0] = 16384;
        set_coefs();
        send(DATAW'($urandom));
        m_ready = 1'b1;
        send(DATAW'($urandom));
        model_out(el, eh);
        lo = '0;
        hi = '0;
        for (int i = 1; i <= 130; i++) begin
            if (!s_ready) lowcnt++;
            if (m_valid && first_v == 0) begin
                first_v = i;
                lo = m_low;
                hi = m_high;
            end
            step();
        end
        checks++;
        if (first_v != 130) begin
            errors++;
            $display("FAIL latency_m_valid: got cycle %0d want 130", first_v);
        end
        checks++;
        if (lowcnt != 130) begin
            errors++;
            $display("FAIL latency_s_ready_low: got %0d want 130", lowcnt);
        end
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_release: got s_ready=%0b m_valid=%0b want 1/0",
                     s_ready, m_valid);
        end
        checks++;
        if (lo !== el || hi !== eh) begin
            errors++;
            $display("FAIL latency_value: got %0d/%0d want %0d/%0d",
                     lo, hi, el, eh);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_saturation;
        logic signed [DATAW-1:0] el, eh, lo, hi;
        logic signed [DATAW-1:0] v;
        for (int i = 0; i < NTAPS; i++) hm[i] = 32767;
        set_coefs();
        for (int pass = 0; pass < 2; pass++) begin
            v = (pass == 0) ? 16'sh7fff : 16'sh8000;
            for (int p = 0; p < NTAPS / 2; p++) begin
                send(v);
                send(v);
                model_out(el, eh);
                wait_out(0, lo, hi);
                checks++;
                if (lo !== el || hi !== eh) begin
                    errors++;
                    $display("FAIL sat_pair%0d_%0d: got %0d/%0d want %0d/%0d",
                             pass, p, lo, hi, el, eh);
                end
            end
            el = (pass == 0) ? 16'sh7fff : 16'sh8000;
            checks++;
            if (lo !== el || hi !== 16'sd0) begin
                errors++;
                $display("FAIL sat_final%0d: got %0d/%0d want %0d/0",
                         pass, lo, hi, el);
            end
        end
    endtask

    task automatic test_backpressure;
        logic signed [DATAW-1:0] el, eh, lo, hi;
        int n = 0;
        int bad = 0;
        for (int i = 0; i < NTAPS; i++) hm[i] = int'($urandom_range(0, 65535)) - 32768;
        set_coefs();
        send(DATAW'($urandom));
        send(DATAW'($urandom));
        model_out(el, eh);
        while (!m_valid && n < 400) begin
            step();
            n++;
        end
        lo = m_low;
        hi = m_high;
        checks++;
        if (m_valid !== 1'b1 || lo !== el || hi !== eh) begin
            errors++;
            $display("FAIL bp_value: got v=%0b %0d/%0d want 1 %0d/%0d",
                     m_valid, lo, hi, el, eh);
        end
        for (int c = 0; c < 50; c++) begin
            s_valid = 1'($urandom);
            s_data  = DATAW'($urandom);
            step();
            if (m_valid !== 1'b1 || m_low !== lo || m_high !== hi ||
                s_ready !== 1'b0) bad++;
        end
        s_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got m_valid=%0b s_ready=%0b want 0/1",
                     m_valid, s_ready);
        end
        checks++;
        if (m_low !== lo || m_high !== hi) begin
            errors++;
            $display("FAIL bp_retain: got %0d/%0d want %0d/%0d",
                     m_low, m_high, lo, hi);
        end
        send(DATAW'($urandom));
        send(DATAW'($urandom));
        model_out(el, eh);
        wait_out(1, lo, hi);
        checks++;
        if (lo !== el || hi !== eh) begin
            errors++;
            $display("FAIL bp_ignored: got %0d/%0d want %0d/%0d",
                     lo, hi, el, eh);
        end
    endtask

    task automatic test_reset_mid_mac;
        logic signed [DATAW-1:0] lo, hi;
        int seen = 0;
        send(DATAW'($urandom));
        send(DATAW'($urandom));
        repeat (39) step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        model_clear();
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mac_state: got s_ready=%0b m_valid=%0b want 1/0",
                     s_ready, m_valid);
        end
        checks++;
        if (m_low !== '0 || m_high !== '0) begin
            errors++;
            $display("FAIL rst_mac_outs: got %0d/%0d want 0/0", m_low, m_high);
        end
        for (int c = 0; c < 200; c++) begin
            if (m_valid) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mac_no_out: got %0d valid cycles want 0", seen);
        end
        zero_coefs();
        hm[0] = 16384;
        set_coefs();
        send(16'sd1000);
        send(16'sd2000);
        wait_out(0, lo, hi);
        checks++;
        if (lo !== 16'sd1000 || hi !== 16'sd1000) begin
            errors++;
            $display("FAIL rst_mac_tap0: got %0d/%0d want 1000/1000", lo, hi);
        end
    endtask

    task automatic test_random;
        logic signed [DATAW-1:0] el, eh, lo, hi;
        for (int i = 0; i < NTAPS; i++) hm[i] = int'($urandom_range(0, 65535)) - 32768;
        set_coefs();
        for (int p = 0; p < 25; p++) begin
            send(DATAW'($urandom));
            send(DATAW'($urandom));
            model_out(el, eh);
            wait_out(int'($urandom_range(0, 3)), lo, hi);
            checks++;
            if (lo !== el || hi !== eh) begin
                errors++;
                $display("FAIL rand_pair%0d: got %0d/%0d want %0d/%0d",
                         p, lo, hi, el, eh);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tap0();
        test_tap1();
        test_latency();
        test_saturation();
        test_backpressure();
        test_reset_mid_mac();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
